// File: rtl/arm_mc_pkg.sv
// rtl/arm_mc_pkg.sv - shared states, select encodings and cond codes for the multicycle controller
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'ha;
  localparam logic [3:0] COND_LT = 4'hb;
  localparam logic [3:0] COND_GT = 4'hc;
  localparam logic [3:0] COND_LE = 4'hd;
  localparam logic [3:0] COND_AL = 4'he;

  localparam logic [3:0] FUNCT_AND = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0010;
  localparam logic [3:0] FUNCT_ADD = 4'b0100;
  localparam logic [3:0] FUNCT_CMP = 4'b1010;
  localparam logic [3:0] FUNCT_ORR = 4'b1100;

endpackage

// File: rtl/arm_mc_condcheck.sv
// rtl/arm_mc_condcheck.sv - evaluates an ARM condition field against NZCV
module arm_mc_condcheck
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ok_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  // cond 1111 falls to default: treated as never
  always_comb begin
    cond_ok_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ok_o = z;
      COND_NE: cond_ok_o = ~z;
      COND_CS: cond_ok_o = c;
      COND_CC: cond_ok_o = ~c;
      COND_MI: cond_ok_o = n;
      COND_PL: cond_ok_o = ~n;
      COND_VS: cond_ok_o = v;
      COND_VC: cond_ok_o = ~v;
      COND_HI: cond_ok_o = c & ~z;
      COND_LS: cond_ok_o = ~c | z;
      COND_GE: cond_ok_o = (n == v);
      COND_LT: cond_ok_o = (n != v);
      COND_GT: cond_ok_o = ~z & (n == v);
      COND_LE: cond_ok_o = z | (n != v);
      COND_AL: cond_ok_o = 1'b1;
      default: cond_ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// rtl/arm_mc_controller.sv - Moore FSM control unit for the multicycle ARMv4-subset datapath
module arm_mc_controller
  import arm_mc_pkg::*;
#(
  parameter bit SUPPORT_CMP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [3:0]  state_o
);

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ok_q, cond_ok_d;
  logic       cond_ok_now;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       i_bit, s_bit;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign i_bit     = Instr[13];
  assign cmd       = Instr[12:9];
  assign s_bit     = Instr[8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  logic       is_cmp, dp_arith, dp_known;
  logic [1:0] dp_alu_ctrl;

  assign is_cmp = SUPPORT_CMP && (cmd == FUNCT_CMP) && s_bit;

  always_comb begin
    dp_alu_ctrl = ALU_ADD;
    dp_arith    = 1'b0;
    dp_known    = 1'b1;
    case (cmd)
      FUNCT_ADD: dp_arith = 1'b1;
      FUNCT_SUB: begin dp_alu_ctrl = ALU_SUB; dp_arith = 1'b1; end
      FUNCT_AND: dp_alu_ctrl = ALU_AND;
      FUNCT_ORR: dp_alu_ctrl = ALU_ORR;
      default: begin
        if (is_cmp) begin
          dp_alu_ctrl = ALU_SUB;
          dp_arith    = 1'b1;
        end else begin
          dp_known = 1'b0;
        end
      end
    endcase
  end

  arm_mc_condcheck u_condcheck (
    .cond_i    (cond),
    .flags_i   (flags_q),
    .cond_ok_o (cond_ok_now)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      flags_q   <= 4'b0000;
      cond_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ok_q <= cond_ok_d;
    end
  end

  logic pc_we, ir_we, mem_we, reg_we;

  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    cond_ok_d  = cond_ok_q;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    case (state_q)
      FETCH: begin
        ir_we     = 1'b1;
        pc_we     = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        state_d   = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        cond_ok_d = cond_ok_now;
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = i_bit ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = s_bit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_we    = cond_ok_q;
        state_d   = FETCH;
      end
      MEMWR: begin
        AdrSrc  = 1'b1;
        mem_we  = cond_ok_q;
        state_d = FETCH;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state_q == EXECI) ? SRCB_IMM : SRCB_REG;
        ALUControl = dp_alu_ctrl;
        // ALUFlags are same-cycle, so the flag register captures them as this state ends
        if (s_bit && cond_ok_q && dp_known) begin
          flags_d[3:2] = ALUFlags[3:2];
          if (dp_arith) flags_d[1:0] = ALUFlags[1:0];
        end
        state_d = is_cmp ? FETCH : ALUWB;
      end
      ALUWB: begin
        if (rd == 4'hf) pc_we = cond_ok_q;
        else            reg_we = cond_ok_q;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        pc_we     = cond_ok_q;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // state already reads FETCH during reset; only the write strobes need masking
  assign PCWrite  = pc_we  & ~reset;
  assign IRWrite  = ir_we  & ~reset;
  assign MemWrite = mem_we & ~reset;
  assign RegWrite = reg_we & ~reset;

  assign ImmSrc  = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
  assign RegSrc  = {(op == 2'b01) && !s_bit, op == 2'b10};
  assign state_o = state_q;

endmodule

// File: tb/tb_arm_mc_controller.sv
// tb/tb_arm_mc_controller.sv - self-checking bench for arm_mc_controller against an instruction-level model
module tb_arm_mc_controller;
  import arm_mc_pkg::*;

  localparam bit SUPPORT_CMP = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0]  state_o;

  int checks = 0;
  int errors = 0;
  logic [3:0] m_flags;

  arm_mc_controller #(.SUPPORT_CMP(SUPPORT_CMP)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .RegSrc(RegSrc), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // conditions come in pairs: cond[3:1] picks a predicate, cond[0] negates it
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit base;
    case (c[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] && !f[2];
      3'd5: base = (f[3] == f[0]);
      3'd6: base = !f[2] && (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic run_instr(input logic [19:0] ins, input logic [3:0] af, input string tag);
    logic [3:0] cnd, cmd, rd;
    logic [1:0] op, exp_alu;
    logic [5:0] fn;
    bit ok, cmp_ok, arith, logic_op, e_pcw, e_regw, e_memw;
    state_t path[$];
    state_t st;
    cnd = ins[19:16]; op = ins[15:14]; fn = ins[13:8]; rd = ins[3:0]; cmd = fn[4:1];
    ok       = cond_holds(cnd, m_flags);
    cmp_ok   = SUPPORT_CMP && cmd == 4'b1010 && fn[0];
    arith    = cmd == 4'b0100 || cmd == 4'b0010 || cmp_ok;
    logic_op = cmd == 4'b0000 || cmd == 4'b1100;
    case (cmd)
      4'b0010: exp_alu = 2'b01;
      4'b0000: exp_alu = 2'b10;
      4'b1100: exp_alu = 2'b11;
      4'b1010: exp_alu = cmp_ok ? 2'b01 : 2'b00;
      default: exp_alu = 2'b00;
    endcase
    path.push_back(FETCH);
    path.push_back(DECODE);
    case (op)
      2'b01: begin
        path.push_back(MEMADR);
        if (fn[0]) begin path.push_back(MEMRD); path.push_back(MEMWB); end
        else path.push_back(MEMWR);
      end
      2'b00: begin
        path.push_back(fn[5] ? EXECI : EXECR);
        if (!cmp_ok) path.push_back(ALUWB);
      end
      2'b10: path.push_back(BRANCH);
      default: ;
    endcase
    Instr = ins;
    ALUFlags = af;
    #1;
    for (int i = 0; i < path.size(); i++) begin
      st = path[i];
      e_pcw  = (st == FETCH) || (ok && (st == BRANCH || (st == ALUWB && rd == 4'hf)));
      e_regw = ok && (st == MEMWB || (st == ALUWB && rd != 4'hf));
      e_memw = ok && st == MEMWR;
      checks++;
      if (state_o !== st) begin
        errors++; $display("FAIL %s ins=%05h cyc%0d state got %0d want %0d", tag, ins, i, state_o, st);
      end
      checks++;
      if ({PCWrite, RegWrite, MemWrite, IRWrite} !== {e_pcw, e_regw, e_memw, st == FETCH}) begin
        errors++;
        $display("FAIL %s ins=%05h cyc%0d pc/reg/mem/ir got %b%b%b%b want %b%b%b%b", tag, ins, i,
                 PCWrite, RegWrite, MemWrite, IRWrite, e_pcw, e_regw, e_memw, st == FETCH);
      end
      checks++;
      if (AdrSrc !== (st == MEMRD || st == MEMWR)) begin
        errors++; $display("FAIL %s ins=%05h cyc%0d AdrSrc got %b", tag, ins, i, AdrSrc);
      end
      if (st == FETCH || st == DECODE) begin
        checks++;
        if ({ALUSrcA, ALUSrcB, ResultSrc} !== 5'b1_10_10) begin
          errors++; $display("FAIL %s cyc%0d fetch/decode selects got %b%b%b want 11010", tag, i, ALUSrcA, ALUSrcB, ResultSrc);
        end
      end
      if (st == EXECR || st == EXECI) begin
        checks++;
        if ({ALUSrcA, ALUSrcB, ALUControl} !== {1'b0, (st == EXECI) ? 2'b01 : 2'b00, exp_alu}) begin
          errors++; $display("FAIL %s ins=%05h exec srcA/srcB/alu got %b/%b/%b want 0/%b/%b", tag, ins,
                             ALUSrcA, ALUSrcB, ALUControl, (st == EXECI) ? 2'b01 : 2'b00, exp_alu);
        end
      end
      if (st == MEMWB) begin
        checks++;
        if (ResultSrc !== 2'b01) begin
          errors++; $display("FAIL %s memwb ResultSrc got %b want 01", tag, ResultSrc);
        end
      end
      if (st == BRANCH || st == MEMADR) begin
        checks++;
        if ({ALUSrcA, ALUSrcB, ALUControl} !== 5'b0_01_00) begin
          errors++; $display("FAIL %s cyc%0d addr-calc selects got %b%b%b want 00100", tag, i, ALUSrcA, ALUSrcB, ALUControl);
        end
      end
      if (i == 0) begin
        checks++;
        if (RegSrc !== {op == 2'b01 && !fn[0], op == 2'b10}) begin
          errors++; $display("FAIL %s ins=%05h RegSrc got %b", tag, ins, RegSrc);
        end
        if (op != 2'b11) begin
          checks++;
          if (ImmSrc !== op) begin
            errors++; $display("FAIL %s ins=%05h ImmSrc got %b want %b", tag, ins, ImmSrc, op);
          end
        end
      end
      @(posedge clk); #1;
    end
    if (op == 2'b00 && fn[0] && ok && (arith || logic_op)) begin
      m_flags[3:2] = af[3:2];
      if (arith) m_flags[1:0] = af[1:0];
    end
    checks++;
    if (dut.flags_q !== m_flags) begin
      errors++; $display("FAIL %s ins=%05h flags got %b want %b", tag, ins, dut.flags_q, m_flags);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Instr = 20'h0; ALUFlags = 4'h0; m_flags = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (state_o !== FETCH || IRWrite !== 1'b1) begin
      errors++; $display("FAIL reset_release state got %0d IRWrite got %b want 0/1", state_o, IRWrite);
    end
    run_instr(20'hE0523, 4'b1111, "pre_reset_subs");
    Instr = 20'hE0523;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (state_o !== EXECR) begin
      errors++; $display("FAIL reset_setup state got %0d want %0d", state_o, EXECR);
    end
    #2 reset = 1'b1;
    #1;
    m_flags = 4'h0;
    checks++;
    if (state_o !== FETCH || {PCWrite, RegWrite, IRWrite, MemWrite} !== 4'b0 || dut.flags_q !== 4'b0) begin
      errors++; $display("FAIL reset_async state %0d strobes %b%b%b%b flags %b want 0 0000 0000",
                         state_o, PCWrite, RegWrite, IRWrite, MemWrite, dut.flags_q);
    end
    @(posedge clk); #1;
    checks++;
    if (state_o !== FETCH || PCWrite !== 1'b0 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL reset_hold state %0d PCWrite %b RegWrite %b want 0 0 0", state_o, PCWrite, RegWrite);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (state_o !== FETCH || IRWrite !== 1'b1) begin
      errors++; $display("FAIL reset_first_fetch state %0d IRWrite %b want 0 1", state_o, IRWrite);
    end
  endtask

  task automatic test_dp_imm();
    run_instr(20'hE2802, 4'b1011, "add_imm");
  endtask

  task automatic test_flags_branch();
    run_instr(20'hE0523, 4'b0110, "subs");
    checks++;
    if (dut.flags_q !== 4'b0110) begin
      errors++; $display("FAIL subs_flags got %b want 0110", dut.flags_q);
    end
    run_instr(20'h0A000, 4'b0000, "beq_taken");
    run_instr(20'hE0523, 4'b0000, "subs_nz");
    run_instr(20'h0A000, 4'b0100, "beq_not_taken");
  endtask

  task automatic test_ldr();
    run_instr(20'hE5901, 4'b0000, "ldr");
  endtask

  task automatic test_str();
    run_instr(20'hE5801, 4'b0000, "str");
    run_instr(20'hE0523, 4'b0100, "subs_z");
    run_instr(20'h15801, 4'b0000, "strne_skip");
  endtask

  task automatic test_cmp_pcwrite();
    run_instr(20'hE1520, 4'b1001, "cmp");
    run_instr(20'hE082F, 4'b0000, "add_pc");
    run_instr(20'hF082F, 4'b0000, "add_pc_never");
  endtask

  task automatic test_random();
    logic [19:0] ins;
    logic [3:0] pick [4];
    pick[0] = 4'b0100; pick[1] = 4'b0010; pick[2] = 4'b0000; pick[3] = 4'b1100;
    for (int k = 0; k < 250; k++) begin
      ins = 20'($urandom);
      if ($urandom_range(0, 2) != 0) ins[19:16] = 4'hE;
      if ($urandom_range(0, 3) == 0) ins[3:0] = 4'hF;
      if ($urandom_range(0, 1) == 0) ins[12:9] = pick[$urandom_range(0, 3)];
      if ($urandom_range(0, 5) == 0) begin ins[12:9] = 4'b1010; ins[15:14] = 2'b00; end
      run_instr(ins, 4'($urandom), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_dp_imm();
    test_flags_branch();
    test_ldr();
    test_str();
    test_cmp_pcwrite();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
